// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and defaults for the fetch PC sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    localparam int PC_W_DEF   = 8;
    localparam int PC_INC_DEF = 1;
    localparam int RAS_DEPTH  = 4;

endpackage

// File: rtl/pc_target_table.sv
// rtl/pc_target_table.sv - jump target register file, one sync write port, one async read port
module pc_target_table #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [W-1:0]     wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    // A same-cycle write is not visible here until the next cycle.
    assign rdata = mem[ridx];

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - fetch PC sequencer with programmable jump table
// Optional return-address stack enabled by defining RET_STACK_EN.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int PC_INC    = PC_INC_DEF,
    parameter int TBL_DEPTH = 8,
    parameter int IDX_W     = $clog2(TBL_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic             jmp_req,
    input  logic [IDX_W-1:0] jmp_idx,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [PC_W-1:0]  cfg_data,
    output logic [PC_W-1:0]  pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             halted
`ifdef RET_STACK_EN
    ,
    input  logic             call,
    input  logic             ret,
    output logic             ras_err
`endif
);

    localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

    seq_state_t      state;
    logic [PC_W-1:0] tbl_rdata;
    logic [PC_W-1:0] redir_pc;
    logic            redir;
    logic            hold_pc;
    logic            accept;

    pc_target_table #(
        .DEPTH(TBL_DEPTH),
        .W    (PC_W),
        .IDX_W(IDX_W)
    ) u_table (
        .clk  (clk),
        .rst  (rst),
        .we   (cfg_we),
        .widx (cfg_idx),
        .wdata(cfg_data),
        .ridx (jmp_idx),
        .rdata(tbl_rdata)
    );

    assign accept = (state == RUN) && !stall && !halt_req;

`ifdef RET_STACK_EN
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  ras_stk [RAS_DEPTH];
    logic [CNT_W-1:0] ras_cnt;
    logic             do_push;
    logic             do_pop;

    // Stack slot 0 is the top; overflow shifts the oldest entry out of the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_stk[i] <= '0;
        end else if (do_push) begin
            ras_stk[0] <= pc + INC;
            for (int i = 1; i < RAS_DEPTH; i++) ras_stk[i] <= ras_stk[i-1];
            if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
        end else if (do_pop) begin
            for (int i = 0; i < RAS_DEPTH - 1; i++) ras_stk[i] <= ras_stk[i+1];
            ras_stk[RAS_DEPTH-1] <= '0;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end
`endif

    always_comb begin
        redir    = 1'b0;
        redir_pc = pc;
        hold_pc  = 1'b0;
`ifdef RET_STACK_EN
        do_push  = 1'b0;
        do_pop   = 1'b0;
        if (ret) begin
            if (ras_cnt != '0) begin
                redir    = 1'b1;
                redir_pc = ras_stk[0];
                do_pop   = accept;
            end else begin
                hold_pc  = 1'b1;
            end
        end else if (call) begin
            redir    = 1'b1;
            redir_pc = tbl_rdata;
            do_push  = accept;
        end else
`endif
        if (jmp_req) begin
            redir    = 1'b1;
            redir_pc = tbl_rdata;
        end else if (br_taken) begin
            redir    = 1'b1;
            redir_pc = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            pc_valid <= 1'b0;
            flush    <= 1'b0;
            halted   <= 1'b0;
`ifdef RET_STACK_EN
            ras_err  <= 1'b0;
`endif
        end else begin
            flush <= 1'b0;
`ifdef RET_STACK_EN
            ras_err <= 1'b0;
`endif
            if (halt_req) begin
                state    <= HALT;
                halted   <= 1'b1;
                pc_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= RUN;
                            pc       <= '0;
                            pc_valid <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!stall) begin
                            if (redir) begin
                                state    <= REDIR;
                                pc       <= redir_pc;
                                pc_valid <= 1'b0;
                                flush    <= 1'b1;
                            end else if (hold_pc) begin
`ifdef RET_STACK_EN
                                ras_err  <= 1'b1;
`endif
                            end else begin
                                pc <= pc + INC;
                            end
                        end
                    end
                    // Redirect target sits in pc for one invalid cycle, then fetch resumes past it.
                    REDIR: begin
                        state    <= RUN;
                        pc       <= pc + INC;
                        pc_valid <= 1'b1;
                    end
                    HALT: begin
                        if (start) begin
                            state    <= RUN;
                            halted   <= 1'b0;
                            pc_valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - vector-table and scoreboard bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

    typedef struct {
        bit       rst, start, halt, stall, br;
        bit [7:0] brt;
        bit       jmp;
        bit [2:0] jidx;
        bit       we;
        bit [2:0] widx;
        bit [7:0] wdata;
        bit       call, ret;
        bit [7:0] e_pc;
        bit       e_valid, e_flush, e_halted, e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, halt_req = 1'b0, stall = 1'b0;
    logic       br_taken = 1'b0, jmp_req = 1'b0, cfg_we = 1'b0;
    logic [7:0] br_target = '0, cfg_data = '0;
    logic [2:0] jmp_idx = '0, cfg_idx = '0;
    logic [7:0] pc;
    logic       pc_valid, flush, halted;
`ifdef RET_STACK_EN
    logic       call = 1'b0, ret = 1'b0, ras_err;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vt[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .halt_req (halt_req),
        .stall    (stall),
        .br_taken (br_taken),
        .br_target(br_target),
        .jmp_req  (jmp_req),
        .jmp_idx  (jmp_idx),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_data (cfg_data),
        .pc       (pc),
        .pc_valid (pc_valid),
        .flush    (flush),
        .halted   (halted)
`ifdef RET_STACK_EN
        ,
        .call     (call),
        .ret      (ret),
        .ras_err  (ras_err)
`endif
    );

    function automatic vec_t mk(bit r, bit s, bit h, bit st, bit b, bit [7:0] bt,
                                bit j, bit [2:0] ji, bit w, bit [2:0] wi, bit [7:0] wd,
                                bit [7:0] ep, bit ev, bit ef, bit eh);
        vec_t v;
        v.rst = r; v.start = s; v.halt = h; v.stall = st; v.br = b; v.brt = bt;
        v.jmp = j; v.jidx = ji; v.we = w; v.widx = wi; v.wdata = wd;
        v.call = 1'b0; v.ret = 1'b0;
        v.e_pc = ep; v.e_valid = ev; v.e_flush = ef; v.e_halted = eh; v.e_err = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst = v.rst; start = v.start; halt_req = v.halt; stall = v.stall;
        br_taken = v.br; br_target = v.brt; jmp_req = v.jmp; jmp_idx = v.jidx;
        cfg_we = v.we; cfg_idx = v.widx; cfg_data = v.wdata;
`ifdef RET_STACK_EN
        call = v.call; ret = v.ret;
`endif
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc", idx, int'(pc), int'(e.e_pc));
        check("pc_valid", idx, int'(pc_valid), int'(e.e_valid));
        check("flush", idx, int'(flush), int'(e.e_flush));
        check("halted", idx, int'(halted), int'(e.e_halted));
`ifdef RET_STACK_EN
        check("ras_err", idx, int'(ras_err), int'(e.e_err));
`endif
    endtask

    initial begin
        vec_t v;
        //               r s h st b brt   j ji w wi wd    pc    v f h
        vt.push_back(mk(1,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,0,0,0));
        vt.push_back(mk(1,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,0,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,0,0,0));
        vt.push_back(mk(0,1,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h01,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h02,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,1,5,8'h96, 8'h03,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,1,2,8'h10, 8'h04,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,1,5,0,0,8'h00, 8'h96,0,1,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h97,1,0,0));
        vt.push_back(mk(0,0,0,0, 1,8'h40,1,2,1,2,8'h30, 8'h10,0,1,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h11,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,1,2,0,0,8'h00, 8'h30,0,1,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,1,2,0,0,8'h00, 8'h31,1,0,0));
        vt.push_back(mk(0,0,0,0, 1,8'h1F,0,0,0,0,8'h00, 8'h1F,0,1,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h20,1,0,0));
        vt.push_back(mk(0,0,0,1, 0,8'h00,0,0,0,0,8'h00, 8'h20,1,0,0));
        vt.push_back(mk(0,0,0,1, 1,8'h55,0,0,0,0,8'h00, 8'h20,1,0,0));
        vt.push_back(mk(0,0,0,1, 0,8'h00,0,0,0,0,8'h00, 8'h20,1,0,0));
        vt.push_back(mk(0,0,1,1, 0,8'h00,0,0,0,0,8'h00, 8'h20,0,0,1));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h20,0,0,1));
        vt.push_back(mk(0,1,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h20,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h21,1,0,0));
        vt.push_back(mk(0,1,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h22,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,1,7,8'hFE, 8'h23,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,1,7,0,0,8'h00, 8'hFE,0,1,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'hFF,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h01,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,1,7,0,0,8'h00, 8'hFE,0,1,0));
        vt.push_back(mk(0,0,1,0, 0,8'h00,0,0,0,0,8'h00, 8'hFE,0,0,1));
        vt.push_back(mk(0,1,0,0, 0,8'h00,0,0,0,0,8'h00, 8'hFE,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,1,5,0,0,8'h00, 8'h96,0,1,0));
        vt.push_back(mk(1,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,0,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,1,5,0,0,8'h00, 8'h00,0,0,0));
        vt.push_back(mk(0,1,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,1,0,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,1,5,0,0,8'h00, 8'h00,0,1,0));
        vt.push_back(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h01,1,0,0));

        for (int i = 0; i < vt.size(); i++) step(vt[i], i);

        // Halt then reset from HALT; halt beats start in RUN.
        step(mk(0,0,1,0, 0,8'h00,0,0,0,0,8'h00, 8'h01,0,0,1), 100);
        step(mk(1,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,0,0,0), 101);
        step(mk(0,1,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,1,0,0), 102);
        step(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h01,1,0,0), 103);
        step(mk(0,1,1,0, 0,8'h00,1,0,0,0,8'h00, 8'h01,0,0,1), 104);
        step(mk(1,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,0,0,0), 105);

`ifdef RET_STACK_EN
        step(mk(0,1,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h00,1,0,0), 200);
        step(mk(0,0,0,0, 0,8'h00,0,0,1,1,8'h80, 8'h01,1,0,0), 201);
        step(mk(0,0,0,0, 1,8'h0F,0,0,0,0,8'h00, 8'h0F,0,1,0), 202);
        step(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h10,1,0,0), 203);
        v = mk(0,0,0,0, 0,8'h00,0,1,0,0,8'h00, 8'h80,0,1,0); v.call = 1'b1;
        step(v, 204);
        for (int i = 1; i <= 5; i++)
            step(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'(8'h80 + i),1,0,0), 204 + i);
        v = mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h11,0,1,0); v.ret = 1'b1;
        step(v, 210);
        step(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h12,1,0,0), 211);
        v = mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h12,1,0,0); v.ret = 1'b1; v.e_err = 1'b1;
        step(v, 212);
        step(mk(0,0,0,0, 0,8'h00,0,0,0,0,8'h00, 8'h13,1,0,0), 213);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
